serial_divider: RTL and testbench

//  Sequential unsigned N-bit restoring divider: the inverse operation of the

---
 rtl/serial_divider.sv | 144 ++++++++++++++
 tb/tb_serial_divider.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_divider.sv
// serial_divider: multi-cycle unsigned N-bit restoring divider.
// It accepts operands on start and produces one quotient bit per clock, MSB first.
// After N steps it presents the quotient, the remainder and a divide-by-zero flag
// together with a one-cycle done pulse.
module serial_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    prem_q, prem_d;     // partial remainder R, one guard bit
    logic [N-1:0]  shd_q, shd_d;       // dividend shifting out, quotient shifting in
    logic [N-1:0]  dvs_q, dvs_d;       // latched divisor
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rmd_q, rmd_d;
    logic          dz_q, dz_d;

    logic          accept_s;
    logic [N:0]    trial_s;            // T = {R[N-1:0], D[N-1]}
    logic [N+1:0]  sum_s;              // T + ~{0,divisor} + 1 with carry-out on top
    logic          qbit_s;
    logic [N:0]    prem_step_s;
    logic [N-1:0]  shd_step_s;

    // Next-state and datapath step computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        shd_d   = shd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;

        accept_s    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        trial_s     = {prem_q[N-1:0], shd_q[N-1]};
        sum_s       = {1'b0, trial_s} + {1'b0, ~{1'b0, dvs_q}} + (N+2)'(1);
        // Carry-out set means T >= divisor: subtraction succeeds, keep S.
        qbit_s      = sum_s[N+1];
        if (qbit_s) begin
            prem_step_s = sum_s[N:0];
        end else begin
            prem_step_s = trial_s;
        end
        shd_step_s  = {shd_q[N-2:0], qbit_s};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    if (divisor != {N{1'b0}}) begin
                        state_d = S_RUN;
                        cnt_d   = {CW{1'b0}};
                        prem_d  = {(N+1){1'b0}};
                        shd_d   = dividend;
                        dvs_d   = divisor;
                    end else begin
                        // Zero divisor short-circuits straight to a result.
                        state_d = S_DONE;
                        dvs_d   = divisor;
                        quo_d   = {N{1'b1}};
                        rmd_d   = dividend;
                        dz_d    = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                prem_d = prem_step_s;
                shd_d  = shd_step_s;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                    quo_d   = shd_step_s;
                    rmd_d   = prem_step_s[N-1:0];
                    dz_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and result registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            prem_q  <= {(N+1){1'b0}};
            shd_q   <= {N{1'b0}};
            dvs_q   <= {N{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= {N{1'b0}};
            rmd_q   <= {N{1'b0}};
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            shd_q   <= shd_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_serial_divider.sv
// Scoreboard bench for serial_divider (N=8): the driver pushes the expected results and done edge.
// A negedge monitor pops an entry whenever done is seen and compares it.
module tb_serial_divider;

    localparam int N = 8;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         edge_no;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [7:0] divisor = 8'd0;
    logic       busy, done, div_zero;
    logic [7:0] quotient, remainder;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    serial_divider #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp results
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every done against the scoreboard head
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (done && busy) begin
                errors++;
                $display("FAIL done_busy_overlap: done=%0b busy=%0b, required not both 1", done, busy);
            end
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done at edge %0d: q=%0d r=%0d", cyc, quotient, remainder);
                end else begin
                    mon_e = sb.pop_front();
                    if (quotient !== mon_e.q || remainder !== mon_e.r || div_zero !== mon_e.dz
                        || cyc != mon_e.edge_no) begin
                        errors++;
                        $display("FAIL result: got q=%0d r=%0d dz=%0b edge=%0d, required q=%0d r=%0d dz=%0b edge=%0d",
                                 quotient, remainder, div_zero, cyc,
                                 mon_e.q, mon_e.r, mon_e.dz, mon_e.edge_no);
                    end
                end
            end
        end
    end

    // Called at a negedge: present operands for one edge and log the expectation
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q  = eq;
        e.r  = er;
        e.dz = ez;
        e.edge_no = cyc + 1 + ((b == 8'd0) ? 0 : N);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait, with a bound, until every expected result has been seen
    task automatic wait_idle();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d results pending, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    initial begin
        int bcnt;
        logic [7:0] a, b;

        // Reset state
        @(negedge clk);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_done", {7'd0, done}, 8'd0);
        chk("reset_q", quotient, 8'd0);
        chk("reset_r", remainder, 8'd0);
        chk("reset_dz", {7'd0, div_zero}, 8'd0);
        reset = 1'b0;
        @(negedge clk);

        // 100/7 with busy-length measurement
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) bcnt++;
            @(negedge clk);
        end
        chk("busy_cycles_100_7", 8'(bcnt), 8'd8);
        wait_idle();

        // Divide-by-zero: one-cycle latency, busy never rises
        issue(8'd42, 8'd0, 8'hFF, 8'd42, 1'b1);
        bcnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy) bcnt++;
            @(negedge clk);
        end
        chk("busy_cycles_42_0", 8'(bcnt), 8'd0);
        wait_idle();

        // Edge values (first one also clears div_zero)
        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);   wait_idle();
        issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);       wait_idle();
        issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);   wait_idle();
        issue(8'd0, 8'd5, 8'd0, 8'd0, 1'b0);       wait_idle();
        issue(8'd128, 8'd16, 8'd8, 8'd0, 1'b0);    wait_idle();
        issue(8'd1, 8'd255, 8'd0, 8'd1, 1'b0);     wait_idle();

        // Start during RUN is ignored, then a back-to-back start in the DONE cycle
        issue(8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        dividend = 8'd9;
        divisor  = 8'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("done_seen_200_3", {7'd0, done}, 8'd1);
        issue(8'd9, 8'd2, 8'd4, 8'd1, 1'b0);
        wait_idle();

        // Asynchronous reset mid-RUN: outputs clear at once, no done afterwards
        issue(8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_done", {7'd0, done}, 8'd0);
        chk("abort_q", quotient, 8'd0);
        chk("abort_r", remainder, 8'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) @(negedge clk);

        // Pseudo-random operands against an arithmetic reference
        for (int i = 0; i < 100; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (b == 8'd0) issue(a, b, 8'hFF, a, 1'b1);
            else           issue(a, b, a / b, a % b, 1'b0);
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
